// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// regfile_mp : multi-port register file with bypass, scoreboard, clear engine
// Revision   : 1.0
// ============================================================================
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      rd_busy_o,
  input  logic                   w0_en_i,
  input  logic [AW-1:0]          w0_addr_i,
  input  logic [XLEN-1:0]        w0_data_i,
  input  logic                   w1_en_i,
  input  logic [AW-1:0]          w1_addr_i,
  input  logic [XLEN-1:0]        w1_data_i,
  input  logic                   issue_en_i,
  input  logic [AW-1:0]          issue_addr_i,
  input  logic                   clr_req_i,
  output logic                   ready_o
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  state_t             state_q, state_d;
  logic [AW-1:0]      clr_idx_q, clr_idx_d;
  logic [DEPTH-1:0]   busy_q, busy_d;
  logic [XLEN-1:0]    regs_q [DEPTH];
  logic [XLEN-1:0]    regs_d [DEPTH];

  logic ready;
  logic w0_wr;
  logic w1_wr;

  assign ready   = rst && (state_q == ST_READY);
  assign ready_o = ready;

  // w1 loses to w0 on an address collision; x0 is never stored
  assign w0_wr = w0_en_i && (w0_addr_i != '0);
  assign w1_wr = w1_en_i && (w1_addr_i != '0) &&
                 !(w0_wr && (w0_addr_i == w1_addr_i));

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    regs_d    = regs_q;

    if (!rst) begin
      state_d   = ST_CLEAR;
      clr_idx_d = FIRST_IDX;
      busy_d    = '0;
    end else if (state_q == ST_CLEAR) begin
      regs_d[clr_idx_q] = '0;
      if (clr_idx_q == LAST_IDX) begin
        state_d = ST_READY;
      end else begin
        clr_idx_d = clr_idx_q + FIRST_IDX;
      end
    end else if (clr_req_i) begin
      state_d   = ST_CLEAR;
      clr_idx_d = FIRST_IDX;
      busy_d    = '0;
    end else begin
      if (w0_wr) begin
        regs_d[w0_addr_i] = w0_data_i;
      end
      if (w1_wr) begin
        regs_d[w1_addr_i] = w1_data_i;
      end
      // clears first so that a same-cycle issue to the same register wins
      if (w0_en_i) begin
        busy_d[w0_addr_i] = 1'b0;
      end
      if (w1_en_i) begin
        busy_d[w1_addr_i] = 1'b0;
      end
      if (issue_en_i) begin
        busy_d[issue_addr_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_idx_q <= clr_idx_d;
    busy_q    <= busy_d;
    regs_q    <= regs_d;
  end

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] addr;
      logic          w0_hit;
      logic          w1_hit;

      assign addr   = rd_addr_i[k*AW +: AW];
      assign w0_hit = w0_en_i && (w0_addr_i == addr);
      assign w1_hit = w1_en_i && (w1_addr_i == addr);

      assign rd_data_o[k*XLEN +: XLEN] =
        (!ready || (addr == '0)) ? '0        :
        w0_hit                   ? w0_data_i :
        w1_hit                   ? w1_data_i :
                                   regs_q[addr];

      // bypassed data is current, so it is never reported as pending
      assign rd_busy_o[k] = ready && busy_q[addr] && !w0_hit && !w1_hit;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// tb_regfile_mp : directed and randomized checks of regfile_mp against a model
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [14:0] rd_addr;
  logic [95:0] rd_data;
  logic [2:0]  rd_busy;
  logic        w0_en, w1_en, issue_en, clr_req;
  logic [4:0]  w0_addr, w1_addr, issue_addr;
  logic [31:0] w0_data, w1_data;
  logic        ready;

  int errors = 0;
  int checks = 0;

  // reference model: architectural contents, pending set, clear countdown
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  int          m_remain = 31;

  regfile_mp #(.XLEN(32), .DEPTH(32), .AW(5), .NUM_RD(3)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .w0_en_i(w0_en), .w0_addr_i(w0_addr), .w0_data_i(w0_data),
    .w1_en_i(w1_en), .w1_addr_i(w1_addr), .w1_data_i(w1_data),
    .issue_en_i(issue_en), .issue_addr_i(issue_addr),
    .clr_req_i(clr_req), .ready_o(ready)
  );

  always #5 clk = ~clk;

  function automatic logic m_ready();
    return rst && (m_remain == 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (!m_ready() || a == 5'd0) return 32'd0;
    if (w0_en && w0_addr == a) return w0_data;
    if (w1_en && w1_addr == a) return w1_data;
    return m_regs[a];
  endfunction

  function automatic logic m_busy_rd(input logic [4:0] a);
    return m_ready() && m_busy[a] && !(w0_en && w0_addr == a) && !(w1_en && w1_addr == a);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_busy   = 32'd0;
    m_remain = 31;
  endtask

  // one clock edge; model updated from the inputs presented to that edge
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else if (m_remain > 0) begin
      m_remain--;
    end else if (clr_req) begin
      model_clear();
    end else begin
      if (w0_en && w0_addr != 0) m_regs[w0_addr] = w0_data;
      if (w1_en && w1_addr != 0 && !(w0_en && w0_addr == w1_addr)) m_regs[w1_addr] = w1_data;
      if (w0_en) m_busy[w0_addr] = 1'b0;
      if (w1_en) m_busy[w1_addr] = 1'b0;
      if (issue_en) m_busy[issue_addr] = 1'b1;
      m_busy[0] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    w0_en = 0; w1_en = 0; issue_en = 0; clr_req = 0;
    w0_addr = 0; w1_addr = 0; issue_addr = 0;
    w0_data = 0; w1_data = 0;
  endtask

  task automatic set_rd(input int k, input logic [4:0] a);
    rd_addr[k*5 +: 5] = a;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      w0_en = 1; w0_addr = 5; w0_data = 32'hFF;
      set_rd(0, 5); set_rd(1, 5); set_rd(2, 0);
      #1;
      checks++;
      if (ready !== 1'b0 || rd_data !== 96'd0 || rd_busy !== 3'd0) begin
        errors++;
        $display("FAIL reset_outputs: ready=%b data=%h busy=%b required 0/0/0", ready, rd_data, rd_busy);
      end
      tick();
    end
    idle();
    rst = 1'b1;
    #1;
    begin
      int cnt = 0;
      while (ready !== 1'b1 && cnt < 100) begin
        cnt++;
        tick();
        #1;
      end
      checks++;
      if (cnt != 31) begin
        errors++;
        $display("FAIL reset_ready_low_cycles: got %0d required 31", cnt);
      end
    end
    checks++;
    if (ready !== m_ready()) begin
      errors++;
      $display("FAIL reset_ready_model: got %b required %b", ready, m_ready());
    end
    set_rd(0, 5); set_rd(1, 5); set_rd(2, 5);
    #1;
    checks++;
    if (rd_data !== 96'd0) begin
      errors++;
      $display("FAIL reset_x5: got %h required 0", rd_data);
    end
  endtask

  task automatic test_write_bypass();
    idle();
    w0_en = 1; w0_addr = 7; w0_data = 32'hDEADBEEF;
    set_rd(0, 7);
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass_x7: got %h required deadbeef", rd_data[31:0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL stored_x7: got %h required deadbeef", rd_data[31:0]);
    end
    w0_en = 1; w0_addr = 0; w0_data = 32'h1234;
    set_rd(0, 0);
    #1;
    checks++;
    if (rd_data[31:0] !== 32'd0) begin
      errors++;
      $display("FAIL x0_bypass: got %h required 0", rd_data[31:0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[31:0] !== 32'd0) begin
      errors++;
      $display("FAIL x0_stored: got %h required 0", rd_data[31:0]);
    end
  endtask

  task automatic test_conflict();
    idle();
    w0_en = 1; w0_addr = 9; w0_data = 32'h11111111;
    w1_en = 1; w1_addr = 9; w1_data = 32'h22222222;
    set_rd(0, 9); set_rd(1, 9); set_rd(2, 9);
    #1;
    checks++;
    if (rd_data !== {3{32'h11111111}}) begin
      errors++;
      $display("FAIL conflict_bypass: got %h required 3x11111111", rd_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data !== {3{32'h11111111}}) begin
      errors++;
      $display("FAIL conflict_stored: got %h required 3x11111111", rd_data);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    set_rd(0, 3); set_rd(1, 12); set_rd(2, 4);
    issue_en = 1; issue_addr = 12;
    #1;
    checks++;
    if (rd_busy !== 3'b000) begin
      errors++;
      $display("FAIL busy_before_issue_edge: got %b required 000", rd_busy);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy !== 3'b010) begin
      errors++;
      $display("FAIL busy_after_issue: got %b required 010", rd_busy);
    end
    w1_en = 1; w1_addr = 12; w1_data = 32'h55;
    #1;
    checks++;
    if (rd_busy[1] !== 1'b0 || rd_data[63:32] !== 32'h55) begin
      errors++;
      $display("FAIL busy_bypass_write: busy=%b data=%h required 0/00000055", rd_busy[1], rd_data[63:32]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL busy_cleared: got %b required 0", rd_busy[1]);
    end
    issue_en = 1; issue_addr = 12;
    w0_en = 1; w0_addr = 12; w0_data = 32'h66;
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy[1] !== 1'b1 || rd_data[63:32] !== 32'h66) begin
      errors++;
      $display("FAIL busy_set_wins: busy=%b data=%h required 1/00000066", rd_busy[1], rd_data[63:32]);
    end
  endtask

  // counts ready-low samples until ready returns; optional write attempt to x3
  task automatic wait_clear(input string name, input logic poke);
    int cnt = 0;
    #1;
    while (ready !== 1'b1 && cnt < 100) begin
      cnt++;
      if (poke && cnt == 5) begin
        w0_en = 1; w0_addr = 3; w0_data = 32'hBAD0BAD0;
        issue_en = 1; issue_addr = 3;
        set_rd(0, 3);
        #1;
        checks++;
        if (rd_data[31:0] !== 32'd0 || ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_read_during_clear: data=%h ready=%b required 0/0", name, rd_data[31:0], ready);
        end
      end
      tick();
      idle();
      #1;
    end
    checks++;
    if (cnt != 31) begin
      errors++;
      $display("FAIL %s_ready_low_cycles: got %0d required 31", name, cnt);
    end
    for (int a = 0; a < 32; a++) begin
      set_rd(0, a[4:0]); set_rd(1, a[4:0]); set_rd(2, a[4:0]);
      #1;
      checks++;
      if (rd_data !== 96'd0 || rd_busy !== 3'd0) begin
        errors++;
        $display("FAIL %s_zero_x%0d: data=%h busy=%b required 0/0", name, a, rd_data, rd_busy);
      end
    end
  endtask

  task automatic test_clear();
    idle();
    for (int i = 1; i < 32; i++) begin
      w0_en = 1; w0_addr = i[4:0]; w0_data = 32'hA5000000 | i;
      issue_en = 1; issue_addr = i[4:0];
      tick();
    end
    idle();
    set_rd(0, 31);
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hA500001F || rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL fill_x31: data=%h busy=%b required a500001f/1", rd_data[31:0], rd_busy[0]);
    end
    clr_req = 1;
    w1_en = 1; w1_addr = 20; w1_data = 32'h12345678;
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_req_ready: got %b required 1", ready);
    end
    tick();
    idle();
    wait_clear("clear", 1'b1);
  endtask

  task automatic test_reset_mid_clear();
    idle();
    w0_en = 1; w0_addr = 6; w0_data = 32'h77;
    tick();
    idle();
    clr_req = 1;
    tick();
    idle();
    repeat (9) tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL midclear_ready_in_reset: got %b required 0", ready);
    end
    tick();
    tick();
    rst = 1'b1;
    wait_clear("midclear", 1'b0);
  endtask

  task automatic test_random();
    idle();
    for (int it = 0; it < 500; it++) begin
      w0_en      = $urandom_range(0, 1);
      w1_en      = $urandom_range(0, 1);
      issue_en   = $urandom_range(0, 1);
      w0_addr    = $urandom_range(0, 31);
      w1_addr    = ($urandom_range(0, 3) == 0) ? w0_addr : 5'($urandom_range(0, 31));
      issue_addr = ($urandom_range(0, 3) == 0) ? w1_addr : 5'($urandom_range(0, 31));
      w0_data    = $urandom;
      w1_data    = $urandom;
      clr_req    = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < 3; k++) begin
        case ($urandom_range(0, 3))
          0: set_rd(k, w0_addr);
          1: set_rd(k, w1_addr);
          2: set_rd(k, issue_addr);
          default: set_rd(k, 5'($urandom_range(0, 31)));
        endcase
      end
      #1;
      checks++;
      if (ready !== m_ready()) begin
        errors++;
        $display("FAIL rand_ready it=%0d: got %b required %b", it, ready, m_ready());
      end
      for (int k = 0; k < 3; k++) begin
        logic [4:0] a;
        a = rd_addr[k*5 +: 5];
        checks++;
        if (rd_data[k*32 +: 32] !== m_read(a) || rd_busy[k] !== m_busy_rd(a)) begin
          errors++;
          $display("FAIL rand_port%0d it=%0d x%0d: data=%h busy=%b required %h/%b",
                   k, it, a, rd_data[k*32 +: 32], rd_busy[k], m_read(a), m_busy_rd(a));
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rd_addr = '0;
    model_clear();
    #1;
    test_reset();
    test_write_bypass();
    test_conflict();
    test_scoreboard();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
